// File: rtl/reg32.sv
// General-purpose storage register with synchronous load enable and
// synchronous active-high reset. Serves as the PC, pipeline and register-file word.
module reg32 #(
  parameter int unsigned           WIDTH       = 32,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset outranks load, so X on load/d during reset cannot reach q.
  always_ff @(posedge clk) begin
    if (rst)
      q <= RESET_VALUE;
    else if (load)
      q <= d;
  end

endmodule

// File: tb/tb_reg32.sv
// Self-checking bench for reg32: directed test-plan steps followed by random
// traffic, all compared against a reference register kept in the bench.
module tb_reg32;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [31:0] d;
  logic [31:0] q;

  int unsigned passed = 0;
  int unsigned total  = 0;

  // Reference state: what q must hold, and whether it is defined yet.
  logic [31:0] model;
  bit          known = 1'b0;

  reg32 #(.WIDTH(32), .RESET_VALUE(32'h0)) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .d    (d),
    .q    (q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] expv);
    total++;
    assert (q === expv) passed++;
    else $error("FAIL %s: q=%h expected=%h", tag, q, expv);
  endtask

  // Drive inputs mid-cycle, confirm q has not moved before the edge,
  // then apply the register rules to the model and check after the edge.
  task automatic step(input string tag, input logic r, input logic l,
                      input logic [31:0] dv);
    @(negedge clk);
    rst  = r;
    load = l;
    d    = dv;
    #1;
    if (known) check({tag, "/pre"}, model);
    @(posedge clk);
    #1;
    if (r === 1'b1) begin
      model = 32'h0;
      known = 1'b1;
    end else if (l === 1'b1) begin
      model = dv;
    end
    check(tag, model);
  endtask

  initial begin
    rst  = 1'b0;
    load = 1'b0;
    d    = '0;

    step("reset_x",      1'b1, 1'bx, 32'hxxxx_xxxx);
    step("hold_after",   1'b0, 1'b0, 32'h0000_0005);
    step("load5",        1'b0, 1'b1, 32'h0000_0005);
    step("hold_dead",    1'b0, 1'b0, 32'hDEAD_BEEF);
    step("hold_zero",    1'b0, 1'b0, 32'h0000_0000);
    step("hold_ones",    1'b0, 1'b0, 32'hFFFF_FFFF);
    step("load_ones",    1'b0, 1'b1, 32'hFFFF_FFFF);
    step("load_8001",    1'b0, 1'b1, 32'h8000_0001);
    step("load_zero",    1'b0, 1'b1, 32'h0000_0000);
    step("load_1234",    1'b0, 1'b1, 32'h1234_5678);
    step("rst_prio",     1'b1, 1'b1, 32'hCAFE_BABE);
    step("after_rst",    1'b0, 1'b1, 32'hCAFE_BABE);
    step("hold_cafe",    1'b0, 1'b0, 32'h0BAD_F00D);

    for (int i = 0; i < 200; i++) begin
      logic        r;
      logic        l;
      logic [31:0] dv;
      r  = ($urandom_range(0, 15) == 0);
      l  = 1'($urandom_range(0, 1));
      dv = $urandom;
      if (r && ($urandom_range(0, 3) == 0)) begin
        step("rand_rst_x", r, 1'bx, 32'hxxxx_xxxx);
      end else begin
        step("rand", r, l, dv);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
